envelope_source: RTL and testbench
==================================

Name: envelope_source

Overview:
- Producer side of the amplitude/next sample interface: converts a signed I/Q baseband stream into unsigned 16-bit envelope samples, each marked by a one-cycle `next` strobe.
- Downstream consumers (averager, AGC, squelch) latch `amplitude` on `next`.
- Sits after the downconverter/decimator in the receive chain.
- One envelope value per WINDOW input samples: either the window peak or the window mean.

Parameters:
- LOG2_WINDOW, 2: window length is 2**LOG2_WINDOW valid input samples; legal range 1..10.
- WIDTH, 16: input sample width (signed) and output amplitude width (unsigned).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- i_data  in  WIDTH  signed in-phase sample.
- q_data  in  WIDTH  signed quadrature sample.
- data_valid  in  1  i_data/q_data are valid this cycle; arbitrary gaps allowed.
- mode  in  1  0 = window peak, 1 = window mean; sampled at the first sample of each window.
- amplitude  out  WIDTH  envelope value; held between strobes.
- next  out  1  one-cycle strobe; amplitude is valid in the same cycle.

Behaviour:
- Reset: amplitude=0, next=0, sample counter=0, peak=0, accumulator=0, pipeline valid bits=0, latched mode=0.
- Reset mid-window discards the partial window; no strobe is produced for it.

Magnitude pipeline (3 registered stages, advances every cycle, valid bit follows data_valid):
- S1: a=|I|, b=|Q|. Saturate the most negative value: -32768 -> 32767.
- S2: mx=max(a,b), mn=min(a,b).
- S3: mag = mx + (mn>>1), unsigned, 16 bits. Maximum is 32767+16383=49150, so no overflow.

Window stage (acts on S3-valid cycles only):
- Sample counter cnt runs 0..2**LOG2_WINDOW-1 and wraps.
- When cnt==0, latch `mode`.
- Peak mode: peak <= (cnt==0) ? mag : max(peak, mag).
- Mean mode: acc <= (cnt==0) ? mag : acc+mag. acc is WIDTH+LOG2_WINDOW bits, so it cannot overflow.
- On the last sample of the window (cnt==2**LOG2_WINDOW-1), the next clock edge registers:
  - amplitude = peak mode ? max(peak, mag) : (acc+mag)>>LOG2_WINDOW, truncated (floor);
  - next = 1 for exactly one cycle;
  - cnt wraps to 0.
- Latency: `next` rises 4 clocks after the data_valid cycle of the last sample in the window.
- Strobe spacing: at least 2**LOG2_WINDOW cycles apart. Back-to-back valid input gives exactly one strobe per 2**LOG2_WINDOW cycles.
- `mode` changes inside a window take effect at the next window start only.
- data_valid low: pipeline bubbles propagate; window state is unchanged; amplitude holds.

Test Plan:
- LOG2_WINDOW=2, mode=0, continuous valid, I=1000, Q=0 -> next pulses every 4 cycles, each with amplitude=1000. First pulse arrives 4 cycles after the 4th valid sample.
- I=-300, Q=400 held, mode=0 -> amplitude=550. I=-32768, Q=-32768 -> amplitude=49150 (saturation path).
- mode=1, Q=0, I sequence 100, -200, 300, 401 -> amplitude=250 (1001>>2, truncated). Same sequence with mode=0 -> 401.
- data_valid asserted 1 cycle in 5, I=1900 then I=1960 per window, mode=0 -> exactly one next per 4 valid samples, amplitude 1900 then 1960, next always single-cycle.
- Assert rst for 1 cycle after 2 samples of a window -> amplitude=0, next=0; the next strobe comes only after 4 fresh samples, with a value computed from post-reset samples only.
- Toggle mode 0->1 mid-window -> the current window reports peak; the following window reports mean.

Source files
------------

// File: rtl/envelope_source.sv
// Envelope producer: signed I/Q -> |I/Q| approximation -> per-window peak or mean,
// presented as amplitude with a one-cycle next strobe.
module envelope_source #(
  parameter int LOG2_WINDOW = 2,
  parameter int WIDTH       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic signed [WIDTH-1:0] q_data,
  input  logic                    data_valid,
  input  logic                    mode,
  output logic [WIDTH-1:0]        amplitude,
  output logic                    next
);

  localparam int STAGES = 3;
  localparam int ACC_W  = WIDTH + LOG2_WINDOW;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // mode rides along with its sample so the window choice lines up with the
  // first input sample of the window, not with whatever is on the pin 3 cycles later
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
    logic             m;
  } s2_t;

  typedef struct packed {
    logic [WIDTH-1:0] mag;
    logic             m;
  } s3_t;

  function automatic logic [WIDTH-1:0] sat_abs(input logic [WIDTH-1:0] x);
    if (x == SMIN)    return SMAX;
    else if (x[WIDTH-1]) return ~x + 1'b1;
    else              return x;
  endfunction

  logic [STAGES:1]        vld_pipe;
  s1_t                    s1;
  s2_t                    s2;
  s3_t                    s3;
  logic [LOG2_WINDOW-1:0] cnt;
  logic                   mode_q;
  logic [WIDTH-1:0]       peak;
  logic [ACC_W-1:0]       acc;

  logic                   first, last, eff_mode;
  logic [WIDTH-1:0]       peak_nxt;
  logic [ACC_W-1:0]       acc_nxt;

  always_comb begin
    first    = (cnt == '0);
    last     = &cnt;
    eff_mode = first ? s3.m : mode_q;
    peak_nxt = (first || s3.mag > peak) ? s3.mag : peak;
    acc_nxt  = first ? ACC_W'(s3.mag) : acc + ACC_W'(s3.mag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      peak      <= '0;
      acc       <= '0;
      amplitude <= '0;
      next      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], data_valid};
      s1.a     <= sat_abs(i_data);
      s1.b     <= sat_abs(q_data);
      s1.m     <= mode;
      s2.mx    <= (s1.a > s1.b) ? s1.a : s1.b;
      s2.mn    <= (s1.a > s1.b) ? s1.b : s1.a;
      s2.m     <= s1.m;
      s3.mag   <= s2.mx + (s2.mn >> 1);
      s3.m     <= s2.m;
      next     <= 1'b0;
      if (vld_pipe[STAGES]) begin
        cnt  <= cnt + LOG2_WINDOW'(1);
        peak <= peak_nxt;
        acc  <= acc_nxt;
        if (first) mode_q <= s3.m;
        if (last) begin
          amplitude <= eff_mode ? acc_nxt[ACC_W-1:LOG2_WINDOW] : peak_nxt;
          next      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_envelope_source.sv
// Directed bench for envelope_source: strobes are logged at negedge and each
// scenario task compares the log against hand-computed values.
module tb_envelope_source;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] i_data, q_data;
  logic               data_valid, mode;
  logic [15:0]        amplitude;
  logic               next;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int multi  = 0;
  logic prev_next = 1'b0;
  int amp_q[$];
  int cyc_q[$];

  envelope_source #(.LOG2_WINDOW(2), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .q_data(q_data),
    .data_valid(data_valid), .mode(mode), .amplitude(amplitude), .next(next)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (next) begin
      amp_q.push_back(int'(amplitude));
      cyc_q.push_back(cyc);
      if (prev_next) multi++;
    end
    prev_next = next;
  end

  task automatic drive(input bit v, input int i, input int q, input bit m);
    data_valid = v;
    i_data     = 16'(i);
    q_data     = 16'(q);
    mode       = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, mode);
  endtask

  task automatic clear_log();
    amp_q.delete();
    cyc_q.delete();
    multi = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (amplitude !== 16'd0) begin errors++; $display("FAIL reset_amp: got %0d want 0", amplitude); end
    checks++;
    if (next !== 1'b0) begin errors++; $display("FAIL reset_next: got %b want 0", next); end
    rst = 1'b0;
    idle(6);
    checks++;
    if (amp_q.size() != 0) begin errors++; $display("FAIL reset_no_strobe: got %0d strobes want 0", amp_q.size()); end
  endtask

  task automatic test_continuous_peak();
    int c4;
    clear_log();
    c4 = 0;
    for (int n = 0; n < 12; n++) begin
      if (n == 3) c4 = cyc;
      drive(1'b1, 1000, 0, 1'b0);
    end
    idle(6);
    checks++;
    if (amp_q.size() != 3) begin
      errors++; $display("FAIL cont_count: got %0d strobes want 3", amp_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (amp_q[k] != 1000) begin errors++; $display("FAIL cont_amp%0d: got %0d want 1000", k, amp_q[k]); end
      end
      checks++;
      if (cyc_q[0] != c4 + 4) begin errors++; $display("FAIL cont_latency: got cycle %0d want %0d", cyc_q[0], c4 + 4); end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (cyc_q[k] - cyc_q[k-1] != 4) begin
          errors++; $display("FAIL cont_spacing%0d: got %0d want 4", k, cyc_q[k] - cyc_q[k-1]);
        end
      end
    end
  endtask

  task automatic test_vectors();
    clear_log();
    for (int n = 0; n < 4; n++) drive(1'b1, -300, 400, 1'b0);
    for (int n = 0; n < 4; n++) drive(1'b1, -32768, -32768, 1'b0);
    idle(6);
    checks++;
    if (amp_q.size() != 2) begin
      errors++; $display("FAIL vec_count: got %0d strobes want 2", amp_q.size());
    end else begin
      checks++;
      if (amp_q[0] != 550) begin errors++; $display("FAIL vec_iq: got %0d want 550", amp_q[0]); end
      checks++;
      if (amp_q[1] != 49150) begin errors++; $display("FAIL vec_sat: got %0d want 49150", amp_q[1]); end
    end
  endtask

  task automatic test_mean_vs_peak();
    int seq[4];
    seq = '{100, -200, 300, 401};
    clear_log();
    for (int n = 0; n < 4; n++) drive(1'b1, seq[n], 0, 1'b1);
    for (int n = 0; n < 4; n++) drive(1'b1, seq[n], 0, 1'b0);
    idle(6);
    checks++;
    if (amp_q.size() != 2) begin
      errors++; $display("FAIL mean_count: got %0d strobes want 2", amp_q.size());
    end else begin
      checks++;
      if (amp_q[0] != 250) begin errors++; $display("FAIL mean_amp: got %0d want 250", amp_q[0]); end
      checks++;
      if (amp_q[1] != 401) begin errors++; $display("FAIL peak_amp: got %0d want 401", amp_q[1]); end
    end
  endtask

  task automatic test_gaps();
    clear_log();
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, (n < 4) ? 1900 : 1960, 0, 1'b0);
      idle(4);
    end
    idle(6);
    checks++;
    if (multi != 0) begin errors++; $display("FAIL gap_single_cycle: got %0d wide strobes want 0", multi); end
    checks++;
    if (amp_q.size() != 2) begin
      errors++; $display("FAIL gap_count: got %0d strobes want 2", amp_q.size());
    end else begin
      checks++;
      if (amp_q[0] != 1900) begin errors++; $display("FAIL gap_amp0: got %0d want 1900", amp_q[0]); end
      checks++;
      if (amp_q[1] != 1960) begin errors++; $display("FAIL gap_amp1: got %0d want 1960", amp_q[1]); end
    end
  endtask

  task automatic test_mode_toggle();
    int seq[4];
    seq = '{100, -200, 300, 401};
    clear_log();
    for (int w = 0; w < 2; w++)
      for (int n = 0; n < 4; n++) drive(1'b1, seq[n], 0, (w == 0 && n == 0) ? 1'b0 : 1'b1);
    idle(6);
    mode = 1'b0;
    checks++;
    if (amp_q.size() != 2) begin
      errors++; $display("FAIL toggle_count: got %0d strobes want 2", amp_q.size());
    end else begin
      checks++;
      if (amp_q[0] != 401) begin errors++; $display("FAIL toggle_cur_peak: got %0d want 401", amp_q[0]); end
      checks++;
      if (amp_q[1] != 250) begin errors++; $display("FAIL toggle_next_mean: got %0d want 250", amp_q[1]); end
    end
  endtask

  task automatic test_reset_mid_window();
    clear_log();
    drive(1'b1, 5000, 0, 1'b0);
    drive(1'b1, 5000, 0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    checks++;
    if (amplitude !== 16'd0) begin errors++; $display("FAIL rstmid_amp: got %0d want 0", amplitude); end
    checks++;
    if (next !== 1'b0) begin errors++; $display("FAIL rstmid_next: got %b want 0", next); end
    for (int n = 0; n < 4; n++) drive(1'b1, 700, 0, 1'b0);
    idle(6);
    checks++;
    if (amp_q.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d strobes want 1", amp_q.size());
    end else begin
      checks++;
      if (amp_q[0] != 700) begin errors++; $display("FAIL rstmid_amp_after: got %0d want 700", amp_q[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; mode = 1'b0; i_data = '0; q_data = '0;
    test_reset();
    test_continuous_peak();
    test_vectors();
    test_mean_vs_peak();
    test_gaps();
    test_mode_toggle();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
